// File: rtl/system_0_button_pio_if.sv
// system_0_button_pio_if: Avalon-MM slave bus bundle for the button PIO.
interface system_0_button_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, read_n, write_n, writedata, input readdata);
    modport slave (input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/system_0_button_pio.sv
// system_0_button_pio: debounced push-button PIO with edge capture, irq mask and Avalon-MM access.
module system_0_button_pio #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 16,
    parameter int EDGE      = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    system_0_button_pio_if.slave bus,
    input  logic [WIDTH-1:0]     in_port_i,
    output logic                 irq_o
);
    localparam logic [15:0] LAST = 16'(DB_CYCLES - 1);
    logic [WIDTH-1:0] sync1_q, sync2_q, db_q, db_d, prev_q, ec_q, ec_d, mask_q, mask_d;
    logic [WIDTH-1:0] edge_w, clr_w, sel_w;
    logic [15:0]      cnt_q [WIDTH];
    logic [15:0]      cnt_d [WIDTH];
    logic [31:0]      rd_q, rd_d;
    logic             irq_q, irq_d, wr_w, rd_w;
    always_comb begin
        db_d = db_q;
        for (int k = 0; k < WIDTH; k++) begin
            cnt_d[k] = (sync2_q[k] == db_q[k] || cnt_q[k] == LAST) ? '0 : cnt_q[k] + 16'd1;
            db_d[k]  = (sync2_q[k] != db_q[k] && cnt_q[k] == LAST) ? sync2_q[k] : db_q[k];
        end
    end
    // Edges are taken only from the debounced level, never from the raw pins.
    always_comb begin
        edge_w = EDGE == 0 ? ~prev_q & db_q : EDGE == 1 ? prev_q & ~db_q : prev_q ^ db_q;
        wr_w   = bus.chipselect & ~bus.write_n;
        rd_w   = bus.chipselect & ~bus.read_n;
        clr_w  = (wr_w && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
        ec_d   = (ec_q & ~clr_w) | edge_w;
        mask_d = (wr_w && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : mask_q;
        sel_w  = bus.address == 2'd0 ? db_q : bus.address == 2'd2 ? mask_q :
                 bus.address == 2'd3 ? ec_q : '0;
        rd_d   = rd_w ? 32'(sel_w) : rd_q;
        irq_d  = |(ec_q & mask_q);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            db_q    <= '1;
            prev_q  <= '1;
            for (int k = 0; k < WIDTH; k++) cnt_q[k] <= '0;
            ec_q    <= '0;
            mask_q  <= '0;
            rd_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= in_port_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            prev_q  <= db_q;
            for (int k = 0; k < WIDTH; k++) cnt_q[k] <= cnt_d[k];
            ec_q    <= ec_d;
            mask_q  <= mask_d;
            rd_q    <= rd_d;
            irq_q   <= irq_d;
        end
    end
    assign bus.readdata = rd_q;
    assign irq_o        = irq_q;
endmodule
